// File: rtl/des_iterative_core_if.sv
`default_nettype none
// ============================================================================
// Module : des_iterative_core_if
// Stream handshakes plus the external F-function hookup of the DES core.
// Rev    : 1.0
// ============================================================================
interface des_iterative_core_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [47:0] f_key;
  logic [31:0] f_rdata;
  logic [31:0] f_result;
  logic [4:0]  round_cnt;

  modport master (
    output in_valid, in_mode, in_data, in_key, out_ready, f_result,
    input  in_ready, out_valid, out_data, f_key, f_rdata, round_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_key, out_ready, f_result,
    output in_ready, out_valid, out_data, f_key, f_rdata, round_cnt
  );
endinterface
`default_nettype wire

// File: rtl/des_iterative_core.sv
`default_nettype none
// ============================================================================
// Module : des_iterative_core
// Iterative DES encrypt/decrypt, one round per clock around an external F-function.
// Rev    : 1.0
// ============================================================================
module des_iterative_core #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input wire                  clk,
  input wire                  rst_n,
  des_iterative_core_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int IP_TBL [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_TBL [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_TBL [56] = '{
    57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3, 60,52,44,36,
    63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6, 61,53,45,37,29,21,13,5, 28,20,12,4};
  localparam int PC2_TBL [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Tables use bit 1 = MSB numbering, hence the width-minus-index mapping.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  function automatic logic two_shift(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        mode_q, mode_d;
  logic [4:0]  round_cnt_q, round_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;

  logic        two_sh;
  logic [27:0] c_rnd, d_rnd;
  logic [31:0] r_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      mode_q      <= 1'b0;
      round_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      mode_q      <= mode_d;
      round_cnt_q <= round_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Key path kept apart from the f_result path so the external F loop stays acyclic.
  // Decrypt uses the unshifted key first and rotates right afterwards (K16..K1).
  always_comb begin
    two_sh      = 1'b0;
    c_rnd       = c_q;
    d_rnd       = d_q;
    bus.f_key   = '0;
    bus.f_rdata = '0;
    if (state_q == S_ROUND) begin
      bus.f_rdata = r_q;
      if (!mode_q) begin
        two_sh    = two_shift(round_cnt_q);
        c_rnd     = rotl28(c_q, two_sh);
        d_rnd     = rotl28(d_q, two_sh);
        bus.f_key = pc2_perm({c_rnd, d_rnd});
      end else begin
        two_sh    = two_shift(5'd17 - round_cnt_q);
        c_rnd     = rotr28(c_q, two_sh);
        d_rnd     = rotr28(d_q, two_sh);
        bus.f_key = pc2_perm({c_q, d_q});
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    mode_d      = mode_q;
    round_cnt_d = round_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    r_mix       = l_q ^ bus.f_result;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          {l_d, r_d}  = ip_perm(bus.in_data);
          {c_d, d_d}  = pc1_perm(bus.in_key);
          mode_d      = bus.in_mode;
          round_cnt_d = 5'd1;
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        c_d = c_rnd;
        d_d = d_rnd;
        l_d = r_q;
        r_d = r_mix;
        if (round_cnt_q == 5'd16) begin
          round_cnt_d = '0;
          out_valid_d = 1'b1;
          out_data_d  = fp_perm({r_mix, r_q});
          state_d     = S_DONE;
        end else begin
          round_cnt_d = round_cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (CLEAR_ON_DONE) begin
            l_d = '0;
            r_d = '0;
            c_d = '0;
            d_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.round_cnt = round_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_des_iterative_core.sv
`default_nettype none
// ============================================================================
// Module : tb_des_iterative_core
// Self-checking bench: behavioural DES model, F-function model, random blocks.
// Rev    : 1.0
// ============================================================================
module tb_des_iterative_core;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3, 60,52,44,36,
    63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6, 61,53,45,37,29,21,13,5, 28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  des_iterative_core_if bus ();
  des_iterative_core_if bus0 ();

  des_iterative_core #(.CLEAR_ON_DONE(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  des_iterative_core #(.CLEAR_ON_DONE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit at FIPS position pos (1 = MSB) of a w-bit value.
  function automatic logic [63:0] bitpos(input logic [63:0] src, input int w, input int pos);
    return (src >> (w - pos)) & 64'd1;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input int sh);
    int unsigned v;
    v = {4'd0, x};
    v = ((v << sh) | (v >> (28 - sh))) & 32'h0FFF_FFFF;
    return v[27:0];
  endfunction

  function automatic logic [31:0] des_f(input logic [47:0] k, input logic [31:0] r);
    logic [47:0] e;
    logic [31:0] s, o;
    int six, row, col;
    e = '0;
    for (int i = 0; i < 48; i++) e = (e << 1) | 48'(bitpos({32'd0, r}, 32, E_T[i]));
    e = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = int'((e >> (42 - 6 * b)) & 48'h3f);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s = (s << 4) | 32'(SBOX[b][row * 16 + col]);
    end
    o = '0;
    for (int i = 0; i < 32; i++) o = (o << 1) | 32'(bitpos({32'd0, s}, 32, P_T[i]));
    return o;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data,
                                         input logic mode, output logic [47:0] k_first,
                                         output logic [63:0] preout, output logic [55:0] cd0);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] x, o;
    logic [31:0] l, r, t;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = (cd << 1) | 56'(bitpos(key, 64, PC1_T[i]));
    cd0 = cd;
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 1; n <= 16; n++) begin
      c = rot28(c, (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2);
      d = rot28(d, (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2);
      ks[n-1] = '0;
      for (int i = 0; i < 48; i++) ks[n-1] = (ks[n-1] << 1) | 48'(bitpos({8'd0, c, d}, 56, PC2_T[i]));
    end
    k_first = mode ? ks[15] : ks[0];
    x = '0;
    for (int i = 0; i < 64; i++) x = (x << 1) | bitpos(data, 64, IP_T[i]);
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ des_f(mode ? ks[15-n] : ks[n], r);
      l = t;
    end
    preout = {r, l};
    o = '0;
    for (int i = 0; i < 64; i++) o = (o << 1) | bitpos(preout, 64, FP_T[i]);
    return o;
  endfunction

  assign bus.f_result   = des_f(bus.f_key, bus.f_rdata);
  assign bus0.f_result  = des_f(bus0.f_key, bus0.f_rdata);
  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_mode   = bus.in_mode;
  assign bus0.in_data   = bus.in_data;
  assign bus0.in_key    = bus.in_key;
  assign bus0.out_ready = bus.out_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full block: accept, 16 rounds, optional back-pressure, handshake, post checks.
  task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic mode,
                           input int hold, output logic [63:0] res, output logic [47:0] k1);
    logic [63:0] exp_out, preout;
    logic [55:0] cd0;
    logic [47:0] exp_k1;
    int cyc;
    exp_out = des_ref(key, data, mode, exp_k1, preout, cd0);
    @(negedge clk);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_wait", 64'(cyc < 50), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_key   = key;
    bus.in_mode  = mode;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_key   = {$urandom, $urandom};
    bus.in_mode  = 1'($urandom);
    @(negedge clk);
    cyc = 0;
    check("round1_cnt", 64'(bus.round_cnt), 64'd1);
    k1 = bus.f_key;
    check("round1_fkey", 64'(k1), 64'(exp_k1));
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'd16);
    res = bus.out_data;
    check("out_data", res, exp_out);
    check("done_in_ready", 64'(bus.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", bus.out_data, exp_out);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_data_held", bus.out_data, exp_out);
    check("post_round_cnt", 64'(bus.round_cnt), 64'd0);
    check("clear_lr", {dut.l_q, dut.r_q}, 64'd0);
    check("clear_cd", 64'({dut.c_q, dut.d_q}), 64'd0);
    check("idle_fkey", 64'(bus.f_key), 64'd0);
    check("idle_frdata", 64'(bus.f_rdata), 64'd0);
    check("retain_lr", {dut0.r_q, dut0.l_q}, preout);
    check("retain_cd", 64'({dut0.c_q, dut0.d_q}), 64'(cd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] res, dp;
    logic [47:0] k1, dk;
    logic [55:0] dc;
    logic [63:0] sk[$], sd[$], qe[$];
    logic        sm[$];
    int          acc_at[3];
    int          cyc, n_acc, n_out;
    logic        acc;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_round_cnt", 64'(bus.round_cnt), 64'd0);
    check("rst_fkey", 64'(bus.f_key), 64'd0);
    rst_n = 1'b1;

    run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0, res, k1);
    check("t1_enc", res, 64'h85E813540F0AB405);
    check("t1_k1", 64'(k1), 64'h1B02EFFC7072);
    run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 0, res, k1);
    check("t2_dec", res, 64'h0123456789ABCDEF);
    check("t2_k16", 64'(k1), 64'hCB3D8B0E17F5);
    run_block(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 10, res, k1);
    check("t3_enc", res, 64'h0000000000000000);

    // Three queued blocks with in_valid held high throughout.
    for (int i = 0; i < 3; i++) begin
      sk.push_back({$urandom, $urandom});
      sd.push_back({$urandom, $urandom});
      sm.push_back(1'($urandom));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_key    = sk[0];
    bus.in_data   = sd[0];
    bus.in_mode   = sm[0];
    cyc = 0; n_acc = 0; n_out = 0;
    while ((n_acc < 3 || n_out < 3) && cyc < 200) begin
      if (bus.out_valid) begin
        if (qe.size() > 0) check("stream_out", bus.out_data, qe.pop_front());
        else check("stream_extra_out", 64'd1, 64'd0);
        n_out++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        if (n_acc < 3) acc_at[n_acc] = cyc;
        else check("stream_extra_accept", 64'd1, 64'd0);
        n_acc++;
        qe.push_back(des_ref(sk[0], sd[0], sm[0], dk, dp, dc));
        void'(sk.pop_front());
        void'(sd.pop_front());
        void'(sm.pop_front());
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sk.size() > 0) begin
          bus.in_key  = sk[0];
          bus.in_data = sd[0];
          bus.in_mode = sm[0];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("stream_timeout", 64'(cyc < 200), 64'd1);
    check("stream_accepts", 64'(n_acc), 64'd3);
    check("stream_outputs", 64'(n_out), 64'd3);
    check("stream_gap1", 64'(acc_at[1] - acc_at[0]), 64'd18);
    check("stream_gap2", 64'(acc_at[2] - acc_at[1]), 64'd18);

    // Asynchronous reset in the middle of round 7.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_key   = 64'h133457799BBCDFF1;
    bus.in_data  = 64'h0123456789ABCDEF;
    bus.in_mode  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (bus.round_cnt != 5'd7 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_round7", 64'(bus.round_cnt), 64'd7);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_round_cnt", 64'(bus.round_cnt), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);
    check("midrst_lr0", {dut0.l_q, dut0.r_q}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0, res, k1);
    check("t5_rerun", res, 64'h85E813540F0AB405);

    for (int i = 0; i < 8; i++) begin
      run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                int'($urandom_range(0, 3)), res, k1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
